mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Sits directly downstream of the EX/MEM pipeline register and drives the data-memory (d-cache) port for the MEM stage.
- Sequences word, byte and indirect (LDI/STI) loads and stores over a request/response handshake.
- Formats load data for the MEM/WB register.
- Raises a stall while an access is outstanding, so the upstream registers hold.

Parameters:
- WORD_W, 16, data and address width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- mem_read  in  1  instruction in EX/MEM is a load (LDR/LDB/LDI)
- mem_write  in  1  instruction in EX/MEM is a store (STR/STB/STI)
- indirect  in  1  LDI/STI; requires two accesses
- byte_op  in  1  LDB/STB
- addr  in  WORD_W  effective address (EX/MEM alu output)
- store_data  in  WORD_W  source-register value for stores
- advance  in  1  pipeline moves MEM->WB this cycle (global !stall from the hazard unit)
- dmem_address  out  WORD_W  d-cache address
- dmem_read  out  1  read request, level, held until dmem_resp
- dmem_write  out  1  write request, level, held until dmem_resp
- dmem_byte_enable  out  2  lane enables, [1]=high byte
- dmem_wdata  out  WORD_W  write data
- dmem_rdata  in  WORD_W  read data, valid with dmem_resp
- dmem_resp  in  1  one-cycle completion pulse
- mem_data  out  WORD_W  formatted load result for MEM/WB
- mem_stall  out  1  MEM stage busy; upstream must hold

Behaviour:
- Reset: state=IDLE; indirect-pointer register, held-data register and mem_data all 0; dmem_read=dmem_write=mem_stall=0; byte_enable=2'b00. Reset mid-access abandons the access immediately; a late dmem_resp arriving in IDLE is ignored.
- States: IDLE, PTR (indirect first read), ACCESS (final access), DONE (result held awaiting advance).
- IDLE:
  - If mem_read|mem_write and indirect: go to PTR.
  - Else if mem_read|mem_write: go to ACCESS.
  - Else stay, with mem_stall=0.
  - The request is driven combinationally in the same cycle the op is seen; dmem_* outputs in IDLE equal those of the target state.
- PTR:
  - dmem_read=1, address={addr[15:1],1'b0}, byte_enable=2'b11.
  - On resp: latch ptr<=dmem_rdata, go to ACCESS.
- ACCESS address and data:
  - Base address = ptr if indirect, else addr.
  - Word op: address={base[15:1],0}, be=2'b11, wdata=store_data.
  - Byte op: address=base, be = base[0] ? 2'b10 : 2'b01, wdata={store_data[7:0],store_data[7:0]}.
  - Indirect is always word.
- ACCESS completion:
  - dmem_read=mem_read, dmem_write=mem_write.
  - On resp with advance=1: go to IDLE.
  - On resp with advance=0: capture the result into the held register and go to DONE.
- DONE:
  - No request issued; mem_data=held value; mem_stall=0.
  - On advance: go to IDLE.
  - Prevents re-issuing a completed access while an unrelated stall freezes EX/MEM.
- mem_data:
  - During the resp cycle of ACCESS, mem_data is formatted dmem_rdata (combinational).
  - Word load: dmem_rdata.
  - LDB: sign-extend of dmem_rdata[15:8] if base[0], else of [7:0].
  - In DONE: the held register. For stores and otherwise: 0.
- mem_stall = 1 in PTR, and in ACCESS/IDLE-issue cycles except the cycle dmem_resp completes the final access. No extra latency beyond memory latency; a 1-cycle memory gives a zero-stall single access.
- mem_read and mem_write both set is illegal (assertion); treated as a read.
- Inputs are guaranteed stable while mem_stall=1.

Decomposition:
- Shared lc3b_types package:
  - lc3b_word, lc3b_mem_wmask (2-bit).
  - State enum mem_access_state_t {IDLE,PTR,ACCESS,DONE}.
  - Lane constants LANE_LO=2'b01, LANE_HI=2'b10, LANE_BOTH=2'b11.
- One natural sub-module, mem_load_format: combinational byte select and sign-extend of load data, reused by any later writeback path.

Test Plan:
- LDR addr=0x1235, rdata=0xBEEF, resp after 3 cycles -> address=0x1234, be=11, mem_stall high for 3 cycles, low on resp cycle, mem_data=0xBEEF.
- LDB addr=0x2001, rdata=0x80AA -> be=10, mem_data=0xFF80; addr=0x2000 -> be=01, mem_data=0xFFAA.
- STB addr=0x3001, store_data=0x1234 -> dmem_write=1, be=10, wdata=0x3434, mem_stall drops on resp.
- LDI addr=0x4000: first read returns 0x5006, second returns 0x0042 -> second address=0x5006, mem_data=0x0042, stall held through both accesses.
- LDR completes with advance=0 for 2 cycles -> DONE, no second dmem_read, mem_data held at 0x0042, mem_stall=0, IDLE after advance.
- reset asserted in PTR, then stray dmem_resp -> all outputs 0, state IDLE, no latch.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared LC-3b types for the MEM stage: word/mask types, access FSM states, lane constants.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE,
        PTR,
        ACCESS,
        DONE
    } mem_access_state_t;

    localparam lc3b_mem_wmask LANE_NONE = 2'b00;
    localparam lc3b_mem_wmask LANE_LO   = 2'b01;
    localparam lc3b_mem_wmask LANE_HI   = 2'b10;
    localparam lc3b_mem_wmask LANE_BOTH = 2'b11;

endpackage

// File: rtl/mem_access_unit_if.sv
// Data-memory (d-cache) request/response bus between the MEM stage and the cache.
interface mem_access_unit_if #(
    parameter int WORD_W = 16
);
    logic [WORD_W-1:0] dmem_address;
    logic              dmem_read;
    logic              dmem_write;
    logic [1:0]        dmem_byte_enable;
    logic [WORD_W-1:0] dmem_wdata;
    logic [WORD_W-1:0] dmem_rdata;
    logic              dmem_resp;

    modport master (
        output dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
        input  dmem_rdata, dmem_resp
    );

    modport slave (
        input  dmem_address, dmem_read, dmem_write, dmem_byte_enable, dmem_wdata,
        output dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/mem_access_unit_load_format.sv
// Load-data formatter: byte-lane select and sign extension for LDB, pass-through for word loads.
module mem_load_format #(
    parameter int WORD_W = 16
) (
    input  logic [WORD_W-1:0] i_rdata,
    input  logic              i_byte_op,
    input  logic              i_hi_byte,
    output logic [WORD_W-1:0] o_data
);

    logic [7:0] w_byte;

    // Pick the addressed byte lane and sign-extend it for byte loads.
    always_comb begin
        w_byte = i_hi_byte ? i_rdata[15:8] : i_rdata[7:0];
        if (i_byte_op) begin
            o_data = {{(WORD_W-8){w_byte[7]}}, w_byte};
        end else begin
            o_data = i_rdata;
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory sequencer: word/byte/indirect loads and stores, load formatting, stall.
module mem_access_unit
    import lc3b_types::*;
#(
    parameter int WORD_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic                indirect,
    input  logic                byte_op,
    input  logic [WORD_W-1:0]   addr,
    input  logic [WORD_W-1:0]   store_data,
    input  logic                advance,
    mem_access_unit_if.master   dmem,
    output logic [WORD_W-1:0]   mem_data,
    output logic                mem_stall
);

    mem_access_state_t r_state;
    mem_access_state_t w_eff_state;
    mem_access_state_t w_next_state;

    logic [WORD_W-1:0] r_ptr;
    logic [WORD_W-1:0] r_held;

    logic              w_op;
    logic              w_is_read;
    logic              w_is_write;
    logic              w_byte;
    logic [WORD_W-1:0] w_base;
    logic [WORD_W-1:0] w_fmt;
    logic              w_ptr_load;
    logic              w_held_load;

    logic [WORD_W-1:0] w_address;
    logic              w_read;
    logic              w_write;
    lc3b_mem_wmask     w_be;
    logic [WORD_W-1:0] w_wdata;
    logic [WORD_W-1:0] w_mem_data;
    logic              w_stall;

    mem_load_format #(.WORD_W(WORD_W)) u_load_format (
        .i_rdata   (dmem.dmem_rdata),
        .i_byte_op (w_byte),
        .i_hi_byte (w_base[0]),
        .o_data    (w_fmt)
    );

    // State and capture registers: FSM state, indirect pointer, result held across a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_held  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_ptr_load) begin
                r_ptr <= dmem.dmem_rdata;
            end
            if (w_held_load) begin
                r_held <= w_mem_data;
            end
        end
    end

    // Next-state, request and result decode. An op seen in IDLE is handled exactly as its
    // target state, so the request issues (and may complete) in the same cycle with no added latency.
    always_comb begin
        w_op        = mem_read | mem_write;
        w_is_read   = mem_read;
        w_is_write  = mem_write & ~mem_read;
        w_byte      = byte_op & ~indirect;
        w_base      = indirect ? r_ptr : addr;

        if (r_state == IDLE && w_op) begin
            w_eff_state = indirect ? PTR : ACCESS;
        end else begin
            w_eff_state = r_state;
        end

        w_next_state = w_eff_state;
        w_ptr_load   = 1'b0;
        w_held_load  = 1'b0;
        w_address    = '0;
        w_read       = 1'b0;
        w_write      = 1'b0;
        w_be         = LANE_NONE;
        w_wdata      = '0;
        w_mem_data   = '0;
        w_stall      = 1'b0;

        case (w_eff_state)
            IDLE: begin
                w_next_state = IDLE;
            end
            PTR: begin
                w_read    = 1'b1;
                w_address = {addr[WORD_W-1:1], 1'b0};
                w_be      = LANE_BOTH;
                w_stall   = 1'b1;
                if (dmem.dmem_resp) begin
                    w_ptr_load   = 1'b1;
                    w_next_state = ACCESS;
                end
            end
            ACCESS: begin
                w_read  = w_is_read;
                w_write = w_is_write;
                if (w_byte) begin
                    w_address = w_base;
                    w_be      = w_base[0] ? LANE_HI : LANE_LO;
                    w_wdata   = {store_data[7:0], store_data[7:0]};
                end else begin
                    w_address = {w_base[WORD_W-1:1], 1'b0};
                    w_be      = LANE_BOTH;
                    w_wdata   = store_data;
                end
                if (dmem.dmem_resp) begin
                    w_mem_data = w_is_read ? w_fmt : '0;
                    if (advance) begin
                        w_next_state = IDLE;
                    end else begin
                        w_held_load  = 1'b1;
                        w_next_state = DONE;
                    end
                end else begin
                    w_stall = 1'b1;
                end
            end
            DONE: begin
                w_mem_data = r_held;
                if (advance) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign dmem.dmem_address     = w_address;
    assign dmem.dmem_read        = w_read;
    assign dmem.dmem_write       = w_write;
    assign dmem.dmem_byte_enable = w_be;
    assign dmem.dmem_wdata       = w_wdata;
    assign mem_data              = w_mem_data;
    assign mem_stall             = w_stall;

    a_no_read_and_write: assert property (@(posedge clk) disable iff (reset) !(mem_read && mem_write));

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        mem_read;
    logic        mem_write;
    logic        indirect;
    logic        byte_op;
    logic [15:0] addr;
    logic [15:0] store_data;
    logic        advance;
    logic [15:0] mem_data;
    logic        mem_stall;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_unit_if #(.WORD_W(16)) dmem_bus ();

    mem_access_unit #(.WORD_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .indirect   (indirect),
        .byte_op    (byte_op),
        .addr       (addr),
        .store_data (store_data),
        .advance    (advance),
        .dmem       (dmem_bus),
        .mem_data   (mem_data),
        .mem_stall  (mem_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Move to the next negedge; inputs change there, outputs are sampled 2ns later.
    task automatic next_cycle;
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        mem_read = 0; mem_write = 0; indirect = 0; byte_op = 0;
        addr = 16'h0000; store_data = 16'h0000; advance = 1;
        dmem_bus.dmem_rdata = 16'h0000; dmem_bus.dmem_resp = 0;
    endtask

    task automatic test_reset;
        reset = 1;
        idle_inputs();
        next_cycle(); next_cycle();
        #2;
        n_checks++; if (dmem_bus.dmem_read !== 1'b0) $display("FAIL rst_read: got %b want 0", dmem_bus.dmem_read); else n_pass++;
        n_checks++; if (dmem_bus.dmem_write !== 1'b0) $display("FAIL rst_write: got %b want 0", dmem_bus.dmem_write); else n_pass++;
        n_checks++; if (dmem_bus.dmem_byte_enable !== 2'b00) $display("FAIL rst_be: got %b want 00", dmem_bus.dmem_byte_enable); else n_pass++;
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL rst_stall: got %b want 0", mem_stall); else n_pass++;
        n_checks++; if (mem_data !== 16'h0000) $display("FAIL rst_mem_data: got %h want 0000", mem_data); else n_pass++;
        next_cycle();
        reset = 0;
    endtask

    task automatic test_ldr;
        next_cycle();
        mem_read = 1; addr = 16'h1235; advance = 1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) next_cycle();
            #2;
            n_checks++; if (dmem_bus.dmem_address !== 16'h1234) $display("FAIL ldr_addr c%0d: got %h want 1234", i, dmem_bus.dmem_address); else n_pass++;
            n_checks++; if (mem_stall !== 1'b1) $display("FAIL ldr_stall c%0d: got %b want 1", i, mem_stall); else n_pass++;
        end
        n_checks++; if (dmem_bus.dmem_byte_enable !== 2'b11) $display("FAIL ldr_be: got %b want 11", dmem_bus.dmem_byte_enable); else n_pass++;
        n_checks++; if (dmem_bus.dmem_read !== 1'b1) $display("FAIL ldr_read: got %b want 1", dmem_bus.dmem_read); else n_pass++;
        next_cycle();
        dmem_bus.dmem_resp = 1; dmem_bus.dmem_rdata = 16'hBEEF;
        #2;
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL ldr_stall_resp: got %b want 0", mem_stall); else n_pass++;
        n_checks++; if (mem_data !== 16'hBEEF) $display("FAIL ldr_data: got %h want BEEF", mem_data); else n_pass++;
        next_cycle();
        idle_inputs();
        #2;
        n_checks++; if (dmem_bus.dmem_read !== 1'b0) $display("FAIL ldr_after_read: got %b want 0", dmem_bus.dmem_read); else n_pass++;
        n_checks++; if (mem_data !== 16'h0000) $display("FAIL ldr_after_data: got %h want 0000", mem_data); else n_pass++;
    endtask

    task automatic test_ldb;
        next_cycle();
        mem_read = 1; byte_op = 1; addr = 16'h2001; advance = 1;
        dmem_bus.dmem_resp = 1; dmem_bus.dmem_rdata = 16'h80AA;
        #2;
        n_checks++; if (dmem_bus.dmem_address !== 16'h2001) $display("FAIL ldb_hi_addr: got %h want 2001", dmem_bus.dmem_address); else n_pass++;
        n_checks++; if (dmem_bus.dmem_byte_enable !== 2'b10) $display("FAIL ldb_hi_be: got %b want 10", dmem_bus.dmem_byte_enable); else n_pass++;
        n_checks++; if (mem_data !== 16'hFF80) $display("FAIL ldb_hi_data: got %h want FF80", mem_data); else n_pass++;
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL ldb_hi_stall: got %b want 0", mem_stall); else n_pass++;
        next_cycle();
        addr = 16'h2000;
        #2;
        n_checks++; if (dmem_bus.dmem_address !== 16'h2000) $display("FAIL ldb_lo_addr: got %h want 2000", dmem_bus.dmem_address); else n_pass++;
        n_checks++; if (dmem_bus.dmem_byte_enable !== 2'b01) $display("FAIL ldb_lo_be: got %b want 01", dmem_bus.dmem_byte_enable); else n_pass++;
        n_checks++; if (mem_data !== 16'hFFAA) $display("FAIL ldb_lo_data: got %h want FFAA", mem_data); else n_pass++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_stb;
        next_cycle();
        mem_write = 1; byte_op = 1; addr = 16'h3001; store_data = 16'h1234; advance = 1;
        #2;
        n_checks++; if (dmem_bus.dmem_write !== 1'b1) $display("FAIL stb_write: got %b want 1", dmem_bus.dmem_write); else n_pass++;
        n_checks++; if (dmem_bus.dmem_read !== 1'b0) $display("FAIL stb_read: got %b want 0", dmem_bus.dmem_read); else n_pass++;
        n_checks++; if (dmem_bus.dmem_byte_enable !== 2'b10) $display("FAIL stb_be: got %b want 10", dmem_bus.dmem_byte_enable); else n_pass++;
        n_checks++; if (dmem_bus.dmem_wdata !== 16'h3434) $display("FAIL stb_wdata: got %h want 3434", dmem_bus.dmem_wdata); else n_pass++;
        n_checks++; if (mem_stall !== 1'b1) $display("FAIL stb_stall: got %b want 1", mem_stall); else n_pass++;
        next_cycle();
        dmem_bus.dmem_resp = 1;
        #2;
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL stb_stall_resp: got %b want 0", mem_stall); else n_pass++;
        n_checks++; if (mem_data !== 16'h0000) $display("FAIL stb_mem_data: got %h want 0000", mem_data); else n_pass++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_ldi;
        next_cycle();
        mem_read = 1; indirect = 1; addr = 16'h4000; advance = 1;
        #2;
        n_checks++; if (dmem_bus.dmem_address !== 16'h4000) $display("FAIL ldi_ptr_addr: got %h want 4000", dmem_bus.dmem_address); else n_pass++;
        n_checks++; if (dmem_bus.dmem_read !== 1'b1) $display("FAIL ldi_ptr_read: got %b want 1", dmem_bus.dmem_read); else n_pass++;
        n_checks++; if (mem_stall !== 1'b1) $display("FAIL ldi_ptr_stall: got %b want 1", mem_stall); else n_pass++;
        next_cycle();
        dmem_bus.dmem_resp = 1; dmem_bus.dmem_rdata = 16'h5006;
        #2;
        n_checks++; if (mem_stall !== 1'b1) $display("FAIL ldi_ptr_resp_stall: got %b want 1", mem_stall); else n_pass++;
        next_cycle();
        dmem_bus.dmem_resp = 0; dmem_bus.dmem_rdata = 16'h0000;
        #2;
        n_checks++; if (dmem_bus.dmem_address !== 16'h5006) $display("FAIL ldi_acc_addr: got %h want 5006", dmem_bus.dmem_address); else n_pass++;
        n_checks++; if (dmem_bus.dmem_byte_enable !== 2'b11) $display("FAIL ldi_acc_be: got %b want 11", dmem_bus.dmem_byte_enable); else n_pass++;
        n_checks++; if (mem_stall !== 1'b1) $display("FAIL ldi_acc_stall: got %b want 1", mem_stall); else n_pass++;
        next_cycle();
        dmem_bus.dmem_resp = 1; dmem_bus.dmem_rdata = 16'h0042;
        #2;
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL ldi_resp_stall: got %b want 0", mem_stall); else n_pass++;
        n_checks++; if (mem_data !== 16'h0042) $display("FAIL ldi_data: got %h want 0042", mem_data); else n_pass++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_done_hold;
        next_cycle();
        mem_read = 1; addr = 16'h0010; advance = 0;
        dmem_bus.dmem_resp = 1; dmem_bus.dmem_rdata = 16'h0042;
        #2;
        n_checks++; if (mem_data !== 16'h0042) $display("FAIL hold_resp_data: got %h want 0042", mem_data); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            dmem_bus.dmem_resp = 0; dmem_bus.dmem_rdata = 16'h0000;
            #2;
            n_checks++; if (dmem_bus.dmem_read !== 1'b0) $display("FAIL hold_read c%0d: got %b want 0", i, dmem_bus.dmem_read); else n_pass++;
            n_checks++; if (mem_data !== 16'h0042) $display("FAIL hold_data c%0d: got %h want 0042", i, mem_data); else n_pass++;
            n_checks++; if (mem_stall !== 1'b0) $display("FAIL hold_stall c%0d: got %b want 0", i, mem_stall); else n_pass++;
        end
        next_cycle();
        advance = 1;
        #2;
        n_checks++; if (mem_data !== 16'h0042) $display("FAIL hold_adv_data: got %h want 0042", mem_data); else n_pass++;
        next_cycle();
        dmem_bus.dmem_resp = 1; dmem_bus.dmem_rdata = 16'h1111;
        #2;
        n_checks++; if (dmem_bus.dmem_read !== 1'b1) $display("FAIL hold_reissue_read: got %b want 1", dmem_bus.dmem_read); else n_pass++;
        n_checks++; if (mem_data !== 16'h1111) $display("FAIL hold_reissue_data: got %h want 1111", mem_data); else n_pass++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_back_to_back;
        next_cycle();
        mem_write = 1; addr = 16'h0101; store_data = 16'hABCD; advance = 1;
        dmem_bus.dmem_resp = 1;
        #2;
        n_checks++; if (dmem_bus.dmem_address !== 16'h0100) $display("FAIL b2b_st_addr: got %h want 0100", dmem_bus.dmem_address); else n_pass++;
        n_checks++; if (dmem_bus.dmem_wdata !== 16'hABCD) $display("FAIL b2b_st_wdata: got %h want ABCD", dmem_bus.dmem_wdata); else n_pass++;
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL b2b_st_stall: got %b want 0", mem_stall); else n_pass++;
        next_cycle();
        mem_write = 0; mem_read = 1; addr = 16'h0200; dmem_bus.dmem_rdata = 16'h5555;
        #2;
        n_checks++; if (dmem_bus.dmem_read !== 1'b1) $display("FAIL b2b_ld_read: got %b want 1", dmem_bus.dmem_read); else n_pass++;
        n_checks++; if (mem_data !== 16'h5555) $display("FAIL b2b_ld_data: got %h want 5555", mem_data); else n_pass++;
        next_cycle();
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        next_cycle();
        mem_read = 1; indirect = 1; addr = 16'h4000; advance = 1;
        next_cycle();
        reset = 1;
        next_cycle();
        idle_inputs();
        next_cycle();
        reset = 0;
        dmem_bus.dmem_resp = 1; dmem_bus.dmem_rdata = 16'hDEAD;
        #2;
        n_checks++; if (dmem_bus.dmem_read !== 1'b0) $display("FAIL rmid_read: got %b want 0", dmem_bus.dmem_read); else n_pass++;
        n_checks++; if (dmem_bus.dmem_byte_enable !== 2'b00) $display("FAIL rmid_be: got %b want 00", dmem_bus.dmem_byte_enable); else n_pass++;
        n_checks++; if (mem_stall !== 1'b0) $display("FAIL rmid_stall: got %b want 0", mem_stall); else n_pass++;
        n_checks++; if (mem_data !== 16'h0000) $display("FAIL rmid_data: got %h want 0000", mem_data); else n_pass++;
        next_cycle();
        dmem_bus.dmem_resp = 0;
        #2;
        n_checks++; if (dmem_bus.dmem_read !== 1'b0) $display("FAIL rmid_after_read: got %b want 0", dmem_bus.dmem_read); else n_pass++;
        n_checks++; if (dmem_bus.dmem_address !== 16'h0000) $display("FAIL rmid_after_addr: got %h want 0000", dmem_bus.dmem_address); else n_pass++;
        n_checks++; if (mem_data !== 16'h0000) $display("FAIL rmid_after_data: got %h want 0000", mem_data); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_ldr();
        test_ldb();
        test_stb();
        test_ldi();
        test_done_hold();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
